// File: rtl/neuron_seq_ctrl_if.sv
// rtl/neuron_seq_ctrl_if.sv - request/strobe bundle between a layer controller and one neuron sequencer
//
// Purpose: groups the neuron sequencer's request inputs and datapath strobes.
// Ports (signals):
//   start, hold          : request and stall from the layer controller
//   sel[IDX_W-1:0]       : operand pair index for the input/weight mux
//   ld_x, ld_w           : operand register load strobes
//   clr_acc, ld_acc      : accumulator clear / accumulate strobes
//   ld_out               : activation/output register load strobe
//   busy, done           : sequencer status
// Modports: master = layer controller side, slave = sequencer side.

interface neuron_seq_ctrl_if #(
    parameter int IDX_W = 2
);
    logic             start;
    logic             hold;
    logic [IDX_W-1:0] sel;
    logic             ld_x;
    logic             ld_w;
    logic             clr_acc;
    logic             ld_acc;
    logic             ld_out;
    logic             busy;
    logic             done;

    modport master (
        output start, hold,
        input  sel, ld_x, ld_w, clr_acc, ld_acc, ld_out, busy, done
    );

    modport slave (
        input  start, hold,
        output sel, ld_x, ld_w, clr_acc, ld_acc, ld_out, busy, done
    );
endinterface

// File: rtl/neuron_seq_ctrl.sv
// rtl/neuron_seq_ctrl.sv - sequencer for one neuron's load-enabled register datapath
//
// Purpose: on start, clears the accumulator, runs N_IN load/accumulate pairs,
// strobes the output register and pulses done.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : neuron_seq_ctrl_if.slave (start/hold in; sel, strobes, busy, done out)

module neuron_seq_ctrl #(
    parameter int N_IN  = 4,
    parameter int IDX_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    neuron_seq_ctrl_if.slave      bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_MAC,
        S_ACT,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic ld_x_c;
    logic ld_w_c;
    logic clr_acc_c;
    logic ld_acc_c;
    logic ld_out_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Strobes depend only on the state register and hold, so reset to IDLE
    // silences every output without waiting for a clock.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ld_x_c    = 1'b0;
        ld_w_c    = 1'b0;
        clr_acc_c = 1'b0;
        ld_acc_c  = 1'b0;
        ld_out_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_acc_c = 1'b1;
                idx_d     = '0;
                state_d   = S_LOAD;
            end
            S_LOAD: begin
                if (!bus.hold) begin
                    ld_x_c  = 1'b1;
                    ld_w_c  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                if (!bus.hold) begin
                    ld_acc_c = 1'b1;
                    // idx stops at the last pair; it is only rewound by CLEAR.
                    if (idx_q == LAST_IDX) begin
                        state_d = S_ACT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_ACT: begin
                ld_out_c = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.sel     = idx_q;
    assign bus.ld_x    = ld_x_c;
    assign bus.ld_w    = ld_w_c;
    assign bus.clr_acc = clr_acc_c;
    assign bus.ld_acc  = ld_acc_c;
    assign bus.ld_out  = ld_out_c;
    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);

endmodule

// File: doc/neuron_seq_ctrl.md
# neuron_seq_ctrl

Sequencer that drives one neuron's register-based datapath: the input/weight operand registers, the accumulator register and the output register, each of which is a load-enabled register (`ld`, `rst`, `clk`). On a `start` pulse it clears the accumulator, then steps through `N_IN` input/weight pairs with a load-then-accumulate cycle per pair. It then strobes the activation/output register and signals `done`. One instance sits beside each neuron datapath under the layer controller.

## Interface
- `N_IN`, default 4: number of input/weight pairs per neuron; legal range 1..2^`IDX_W`.
- `IDX_W`, default 2: width of the operand index `sel`.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request one neuron evaluation; sampled only in IDLE.
- `hold`, input, 1: stall request; freezes sequencing in LOAD and MAC.
- `sel`, output, `IDX_W`: index of the current input/weight pair, for the operand mux.
- `ld_x`, output, 1: load strobe for the input operand register.
- `ld_w`, output, 1: load strobe for the weight operand register.
- `clr_acc`, output, 1: synchronous clear strobe for the accumulator register.
- `ld_acc`, output, 1: load strobe for the accumulator (acc <= acc + x*w).
- `ld_out`, output, 1: load strobe for the activation/output register.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, CLEAR, LOAD, MAC, ACT, DONE. Internal index register `idx` (`IDX_W` bits); `sel` = `idx`.
- **IDLE**
  - All strobes are 0.
  - `start`=1 → CLEAR; otherwise the FSM stays in IDLE.
- **CLEAR**
  - `clr_acc`=1 and `idx` <= 0.
  - Always → LOAD; `hold` is ignored in this state.
- **LOAD**
  - With `hold`=0: `ld_x`=`ld_w`=1 and the FSM → MAC.
  - With `hold`=1: all strobes are 0 and the FSM stays in LOAD.
- **MAC**
  - With `hold`=0: `ld_acc`=1.
  - If `idx`==`N_IN`-1, → ACT; otherwise `idx` <= `idx`+1 and → LOAD.
  - With `hold`=1: all strobes are 0; the FSM and `idx` are unchanged.
- **ACT**
  - `ld_out`=1.
  - Always → DONE; `hold` is ignored.
- **DONE**
  - `done`=1.
  - Always → IDLE; a `start` asserted in this cycle is ignored.
- `start` is ignored in every state other than IDLE; no requests are queued.
- Strobe decoding:
  - Strobes are decoded from the state register and `hold` only, so they are combinational.
  - At most one of {`clr_acc`, `ld_x`/`ld_w`, `ld_acc`, `ld_out`} is active in any cycle.
- `sel` holds the value of `idx` in every state. It stays stable across the LOAD→MAC pair of the same index.
- `idx` never exceeds `N_IN`-1; there is no wrap-around. For `N_IN`=1 there is a single LOAD/MAC pair, then ACT.
- Reset (`rst`=0, at any time, including mid-sequence):
  - Immediately forces IDLE and `idx`=0.
  - Forces `sel`=0 and all strobes, `busy` and `done` to 0.
  - A sequence aborted by reset is not resumed.

## Timing
- Reset values: `sel`=0, `ld_x`=`ld_w`=`clr_acc`=`ld_acc`=`ld_out`=0, `busy`=0, `done`=0.
- Cycle numbering starts from the edge that samples `start`=1 (edge 0):
  - cycle 1: CLEAR.
  - cycles 2k+2 and 2k+3: LOAD and MAC for index k, for k=0..`N_IN`-1.
  - cycle 2·`N_IN`+2: ACT.
  - cycle 2·`N_IN`+3: DONE.
- With no stall, `done` is high 2·`N_IN`+3 cycles after `start`; for `N_IN`=4 that is cycle 11.
- Each cycle with `hold`=1 in LOAD or MAC adds exactly one cycle of latency.
- `busy` rises in cycle 1 and falls after the DONE cycle.
- Back-to-back operation: the earliest accepted next `start` is in the IDLE cycle after DONE. The minimum period between accepted `start` pulses is 2·`N_IN`+4 cycles.
- Datapath contract: registers capture on the edge that ends the cycle in which their strobe is high. The accumulator therefore sees operands loaded one cycle earlier.

## Test plan
- **Reset:** `rst`=0 at t=0, then released → all outputs 0 and `busy`=0. A `start` pulse → `clr_acc`=1 in cycle 1.
- **Nominal run** (`N_IN`=4, `hold`=0): one `start` pulse → `sel` sequence in LOAD/MAC is 0,0,1,1,2,2,3,3. `ld_x`/`ld_w` are high in cycles 2,4,6,8; `ld_acc` in cycles 3,5,7,9; `ld_out` in cycle 10; `done` in cycle 11; `busy` is high in cycles 1–11.
- **Stall:** `hold`=1 for 3 cycles during MAC of index 1 → `ld_acc` is 0 and `sel`=1 while stalled. `done` arrives in cycle 14.
- **Ignored start:** `start` held high through the whole sequence, including DONE → exactly one run. A second run begins only from the IDLE cycle after DONE, so its `clr_acc` is in cycle 13.
- **Reset mid-operation:** `rst`=0 during MAC of index 2 → all outputs go to 0 immediately, with no `done`. A new `start` produces a full 11-cycle run from index 0.
- **Boundary** (`N_IN`=1): `start` → CLEAR, LOAD(`sel`=0), MAC, ACT, then `done` in cycle 5.
